interleaver_pp_ctrl: RTL and testbench

- Parametrised ping-pong block-interleaver controller with integrated address counters and row/column permutation.
- Writes blocks linearly into one of two RAM banks while the opposite bank is read out in permuted order.
- Sits between the CRC attach stage and the encoder and drives the address and enable pins of two external single-port-per-side RAM banks.
- Supports two run-time block lengths, a per-block permute/bypass mode, and an input/output handshake.

---
 rtl/interleaver_pp_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_interleaver_pp_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_pp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interleaver_pp_ctrl
// Description : Ping-pong block-interleaver controller. Blocks are written
//               linearly into one RAM bank while the opposite bank is read
//               back either linearly or in row/column permuted order.
// Revision    : 1.0 - initial release
// ============================================================================
module interleaver_pp_ctrl #(
  parameter int ADDR_W = 13,
  parameter int LEN0   = 1056,
  parameter int LEN1   = 6144,
  parameter int COLS   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              len_sel,
  input  logic              perm_en,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              out_ready,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_last,
  output logic              done,
  output logic              sop_err,
  output logic [1:0]        bank_full
);

  localparam int                CSH          = $clog2(COLS);
  localparam logic [ADDR_W-1:0] c_len0_last  = ADDR_W'(LEN0 - 1);
  localparam logic [ADDR_W-1:0] c_len1_last  = ADDR_W'(LEN1 - 1);
  localparam logic [ADDR_W-1:0] c_rows0_last = ADDR_W'(LEN0 / COLS - 1);
  localparam logic [ADDR_W-1:0] c_rows1_last = ADDR_W'(LEN1 / COLS - 1);
  localparam logic [ADDR_W-1:0] c_cols_last  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] c_one        = ADDR_W'(1);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_READ = 2'd1, R_LAST = 2'd2} rstate_t;

  wstate_t           r_wstate, w_wstate_nxt;
  rstate_t           r_rstate, w_rstate_nxt;
  logic [ADDR_W-1:0] r_wcnt;
  logic              r_wbank, r_rbank;
  logic [1:0]        r_len, r_perm;       // per-bank block attributes
  logic [1:0]        r_bank_full;
  logic [ADDR_W-1:0] r_row, r_col, r_idx;
  logic              r_out_valid, r_out_sop, r_out_last;

  logic              w_accept, w_wr_en, w_sop_err, w_wr_done, w_wlen_sel;
  logic [ADDR_W-1:0] w_wlast;
  logic              w_rperm, w_rlen, w_rd_en, w_at_last, w_rd_done;
  logic [ADDR_W-1:0] w_rows_last, w_rlast_idx, w_rd_addr;

  // Reset holds in_ready low so every output reads 0 while reset is asserted.
  assign in_ready  = ~reset & ~r_bank_full[r_wbank];
  assign w_accept  = in_valid & in_ready;
  assign wr_en     = w_wr_en;
  assign wr_bank   = r_wbank;
  assign wr_addr   = r_wcnt;
  assign sop_err   = w_sop_err;
  assign rd_en     = w_rd_en;
  assign rd_bank   = r_rbank;
  assign rd_addr   = w_rd_addr;
  assign out_valid = r_out_valid;
  assign out_sop   = r_out_sop;
  assign out_last  = r_out_last;
  assign done      = r_out_last;
  assign bank_full = r_bank_full;

  // Write engine state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  // Write engine next state and strobes; the first beat's length comes straight from len_sel.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_en      = 1'b0;
    w_sop_err    = 1'b0;
    w_wr_done    = 1'b0;
    w_wlen_sel   = r_len[r_wbank];
    case (r_wstate)
      W_IDLE: begin
        w_wlen_sel = len_sel;
        if (w_accept) begin
          if (in_sop) begin
            w_wr_en      = 1'b1;
            w_wstate_nxt = W_FILL;
          end else begin
            w_sop_err = 1'b1;
          end
        end
      end
      W_FILL:  w_wr_en = w_accept;
      default: w_wstate_nxt = W_IDLE;
    endcase
    w_wlast = w_wlen_sel ? c_len1_last : c_len0_last;
    if (w_wr_en && (r_wcnt == w_wlast)) begin
      w_wr_done    = 1'b1;
      w_wstate_nxt = W_IDLE;
    end
  end

  // Write address counter, bank toggle and per-bank attribute capture at sop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
      r_len   <= 2'b00;
      r_perm  <= 2'b00;
    end else begin
      if (w_wr_done) begin
        r_wcnt  <= '0;
        r_wbank <= ~r_wbank;
      end else if (w_wr_en) begin
        r_wcnt <= r_wcnt + c_one;
      end
      if ((r_wstate == W_IDLE) && w_wr_en) begin
        r_len[r_wbank]  <= len_sel;
        r_perm[r_wbank] <= perm_en;
      end
    end
  end

  // Read engine state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  // Read address generation, last-beat detection and next state.
  // R_LAST is the single bubble cycle after a block; it behaves like R_IDLE.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rperm      = r_perm[r_rbank];
    w_rlen       = r_len[r_rbank];
    w_rows_last  = w_rlen ? c_rows1_last : c_rows0_last;
    w_rlast_idx  = w_rlen ? c_len1_last : c_len0_last;
    w_rd_en      = (r_rstate == R_READ) & out_ready;
    w_rd_addr    = w_rperm ? ((r_row << CSH) + r_col) : r_idx;
    w_at_last    = w_rperm ? ((r_row == w_rows_last) && (r_col == c_cols_last))
                           : (r_idx == w_rlast_idx);
    w_rd_done    = w_rd_en & w_at_last;
    case (r_rstate)
      R_IDLE, R_LAST: w_rstate_nxt = r_bank_full[r_rbank] ? R_READ : R_IDLE;
      R_READ:         if (w_rd_done) w_rstate_nxt = R_LAST;
      default:        w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read counters: row runs fastest in permuted mode, idx counts every read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_rbank <= 1'b0;
    end else if (w_rd_done) begin
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_rbank <= ~r_rbank;
    end else if (w_rd_en) begin
      r_idx <= r_idx + c_one;
      if (r_row == w_rows_last) begin
        r_row <= '0;
        r_col <= r_col + c_one;
      end else begin
        r_row <= r_row + c_one;
      end
    end
  end

  // Bank ownership: write completion and read completion always touch different banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank_full <= 2'b00;
    end else begin
      if (w_wr_done) r_bank_full[r_wbank] <= 1'b1;
      if (w_rd_done) r_bank_full[r_rbank] <= 1'b0;
    end
  end

  // Output strobes delayed one cycle to line up with RAM read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_rd_en;
      r_out_sop   <= w_rd_en & (r_idx == '0);
      r_out_last  <= w_rd_done;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interleaver_pp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interleaver_pp_ctrl
// Description : Scoreboard bench for interleaver_pp_ctrl. A negedge monitor
//               models bank ownership and write addressing; completed blocks
//               push their expected read-out sequence into a queue that is
//               popped on every rd_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interleaver_pp_ctrl;

  localparam int ADDR_W = 8;
  localparam int LEN0   = 64;
  localparam int LEN1   = 128;
  localparam int COLS   = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0, in_sop = 1'b0, len_sel = 1'b0, perm_en = 1'b0;
  logic              in_ready, wr_en, wr_bank, rd_en, rd_bank;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              out_ready;
  logic              out_valid, out_sop, out_last, done, sop_err;
  logic [1:0]        bank_full;

  interleaver_pp_ctrl #(.ADDR_W(ADDR_W), .LEN0(LEN0), .LEN1(LEN1), .COLS(COLS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop),
    .len_sel(len_sel), .perm_en(perm_en), .in_ready(in_ready), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .out_ready(out_ready), .rd_en(rd_en),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .out_valid(out_valid), .out_sop(out_sop),
    .out_last(out_last), .done(done), .sop_err(sop_err), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model state ----------------
  typedef struct { int addr; int bank; bit sop; bit last; } rd_exp_t;
  rd_exp_t sbq[$];
  logic [1:0] exp_full = 2'b00;
  int wbank_m = 0, wcount_m = 0, blen_m = 0;
  bit bperm_m = 0;
  bit prev_rd = 0, prev_sop = 0, prev_last = 0;

  // Monitor: compare at negedge, then advance the model to the next posedge.
  always @(negedge clk) begin
    logic [1:0] set_b, clr_b;
    bit exp_ready, acc;
    rd_exp_t e;
    set_b = 2'b00;
    clr_b = 2'b00;
    if (reset) begin
      check("reset_outputs", {in_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
                              out_valid, out_sop, out_last, done, sop_err, bank_full}, 0);
      sbq.delete();
      exp_full = 2'b00; wbank_m = 0; wcount_m = 0; blen_m = 0; bperm_m = 0;
      prev_rd = 0; prev_sop = 0; prev_last = 0;
    end else begin
      check("out_strobes", {out_valid, out_sop, out_last, done},
            {prev_rd, prev_rd & prev_sop, prev_rd & prev_last, prev_rd & prev_last});
      check("bank_full", bank_full, exp_full);
      exp_ready = !exp_full[wbank_m];
      check("in_ready", in_ready, exp_ready);
      acc = in_valid && exp_ready;
      if (acc && wcount_m == 0 && !in_sop) begin
        check("sop_err_drop", {sop_err, wr_en}, 2'b10);
      end else if (acc) begin
        check("wr_beat", {sop_err, wr_en, wr_bank, wr_addr},
              {1'b0, 1'b1, 1'(wbank_m), ADDR_W'(wcount_m)});
        if (wcount_m == 0) begin
          blen_m  = len_sel ? LEN1 : LEN0;
          bperm_m = perm_en;
        end
        wcount_m++;
        if (wcount_m == blen_m) begin
          int rows;
          rows = blen_m / COLS;
          for (int k = 0; k < blen_m; k++) begin
            e.addr = bperm_m ? (k % rows) * COLS + k / rows : k;
            e.bank = wbank_m;
            e.sop  = (k == 0);
            e.last = (k == blen_m - 1);
            sbq.push_back(e);
          end
          set_b[wbank_m] = 1'b1;
          wbank_m  = 1 - wbank_m;
          wcount_m = 0;
        end
      end else begin
        check("wr_idle", {sop_err, wr_en}, 2'b00);
      end
      prev_rd = rd_en; prev_sop = 0; prev_last = 0;
      if (rd_en) begin
        check("rd_en_needs_out_ready", out_ready, 1);
        if (sbq.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("rd_beat", {rd_bank, rd_addr}, {1'(e.bank), ADDR_W'(e.addr)});
          prev_sop  = e.sop;
          prev_last = e.last;
          if (e.last) clr_b[e.bank] = 1'b1;
        end
      end
      exp_full = (exp_full | set_b) & ~clr_b;
    end
  end

  // ---------------- downstream ready generator ----------------
  int or_mode = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(9) < 7);
      endcase
    end
  end

  // ---------------- write-side stimulus ----------------
  task automatic send_block(input bit ls, input bit pe, input int gap_pct, input int abort_at);
    int sent, len, waited;
    bit acc;
    sent = 0; waited = 0;
    len = ls ? LEN1 : LEN0;
    while (sent < len) begin
      in_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      if (sent == 0) begin
        in_sop = 1'b1; len_sel = ls; perm_en = pe;
      end else begin
        in_sop  = ($urandom_range(15) == 0);
        len_sel = 1'($urandom_range(1));
        perm_en = 1'($urandom_range(1));
      end
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      waited++;
      if (waited > 4000) begin
        check("in_ready_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
      if (abort_at >= 0 && sent == abort_at) return;
    end
  endtask

  task automatic send_bad_beat();
    int waited;
    bit acc;
    waited = 0;
    acc = 0;
    while (!acc && waited < 4000) begin
      in_valid = 1'b1; in_sop = 1'b0;
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    check("bad_beat_timeout", !acc, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (n < 3000 && !(sbq.size() == 0 && exp_full == 2'b00 && wcount_m == 0)) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", (n >= 3000), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single permuted short block, full-rate downstream
    or_mode = 0;
    send_block(0, 1, 0, -1);
    wait_drain();

    // back-to-back long linear then short permuted, continuous input
    send_block(1, 0, 0, -1);
    send_block(0, 1, 0, -1);
    wait_drain();

    // beat without sop at count 0 is dropped
    send_bad_beat();
    send_block(0, 0, 0, -1);
    wait_drain();

    // alternating downstream ready
    or_mode = 1;
    send_block(0, 1, 0, -1);
    wait_drain();
    or_mode = 0;

    // one idle cycle aligns second write completion with first read completion
    send_block(0, 1, 0, -1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    send_block(0, 0, 0, -1);
    wait_drain();

    // reset in the middle of a fill, then a fresh block
    send_block(0, 1, 0, 30);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send_block(1, 1, 0, -1);
    wait_drain();

    // randomized traffic
    or_mode = 2;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(3) == 0) send_bad_beat();
      send_block(1'($urandom_range(1)), 1'($urandom_range(1)), 30, -1);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
